alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/wb_pkg.sv | 17 +
 rtl/fwd_match.sv | 26 ++
 rtl/alu_result_buffer.sv | 114 +++++++++++
 tb/tb_alu_result_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the writeback entry record for the ALU result buffer.
package wb_pkg;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_IDX_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;
endpackage

// File: rtl/fwd_match.sv
// Youngest-match bypass search over buffer entries ordered oldest (index 0) to youngest.
module fwd_match
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [REG_IDX_W-1:0]  rs,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (valid[k] && entries[k].wen && (entries[k].rd == rs) && (rs != '0)) begin
        hit  = 1'b1;
        data = entries[k].data;
      end
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results awaiting register writeback, with two combinational bypass ports.
module alu_result_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_result,
  input  logic [REG_IDX_W-1:0]       in_rd,
  input  logic                       in_wen,
  input  logic                       in_word,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_data,
  output logic [REG_IDX_W-1:0]       out_rd,
  output logic                       out_wen,
  input  logic [REG_IDX_W-1:0]       fwd_rs1,
  input  logic [REG_IDX_W-1:0]       fwd_rs2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [XLEN-1:0]            fwd_data1,
  output logic [XLEN-1:0]            fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_entry_t            mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  occ_state_t           occ;
  logic                 push;
  logic                 pop;
  wb_entry_t            new_entry;
  wb_entry_t            head;
  wb_entry_t [DEPTH-1:0] ordered;
  logic [DEPTH-1:0]     ordered_valid;

  always_comb begin
    if (count == '0)           occ = OCC_EMPTY;
    else if (count == FULL_CNT) occ = OCC_FULL;
    else                        occ = OCC_PARTIAL;
  end

  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry.data = in_word ? {{32{in_result[31]}}, in_result[31:0]} : in_result;
    new_entry.rd   = in_rd;
    new_entry.wen  = in_wen && (in_rd != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head.data : '0;
  assign out_rd   = out_valid ? head.rd   : '0;
  assign out_wen  = out_valid ? head.wen  : 1'b0;

  // Rotate storage into age order so the matcher needs no pointer knowledge.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ordered[k]       = mem[rd_ptr + PW'(k)];
      ordered_valid[k] = ((PW+1)'(k) < count);
    end
  end

  fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (ordered),
    .valid   (ordered_valid),
    .rs      (fwd_rs1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (ordered),
    .valid   (ordered_valid),
    .rs      (fwd_rs2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed plus randomized checks of alu_result_buffer against a queue-based reference.
module tb_alu_result_buffer;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [63:0] in_result;
  logic [4:0]  in_rd;
  logic        in_wen, in_word, flush;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;
  logic [$clog2(DEPTH):0] count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        wen;
  } model_t;
  model_t q[$];

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_rd(in_rd), .in_wen(in_wen), .in_word(in_word), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fwd(input logic [4:0] rs, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].wen && q[i].rd == rs) begin
          hit = 1'b1;
          d   = q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic h1, h2;
    logic [63:0] d1, d2;
    model_fwd(fwd_rs1, h1, d1);
    model_fwd(fwd_rs2, h2, d2);
    chk({tag, ".count"},    64'(count),     64'(q.size()));
    chk({tag, ".in_ready"}, 64'(in_ready),  64'(q.size() < DEPTH));
    chk({tag, ".out_valid"},64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".out_data"}, out_data,       q.size() != 0 ? q[0].data : 64'd0);
    chk({tag, ".out_rd"},   64'(out_rd),    q.size() != 0 ? 64'(q[0].rd) : 64'd0);
    chk({tag, ".out_wen"},  64'(out_wen),   q.size() != 0 ? 64'(q[0].wen) : 64'd0);
    chk({tag, ".fwd_hit1"}, 64'(fwd_hit1),  64'(h1));
    chk({tag, ".fwd_data1"},fwd_data1,      d1);
    chk({tag, ".fwd_hit2"}, 64'(fwd_hit2),  64'(h2));
    chk({tag, ".fwd_data2"},fwd_data2,      d2);
  endtask

  // Model update for one rising edge, using the inputs held during that cycle.
  task automatic model_edge();
    bit do_push, do_pop;
    model_t e;
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.data = in_word ? {{32{in_result[31]}}, in_result[31:0]} : in_result;
        e.rd   = in_rd;
        e.wen  = in_wen && (in_rd != 0);
        q.push_back(e);
      end
    end
  endtask

  task automatic tick(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [4:0] rd,
                       input logic wen, input logic word, input logic fl, input logic ordy);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    in_wen    = wen;
    in_word   = word;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    reset_n = 1'b0;
    fwd_rs1 = 5'd0;
    fwd_rs2 = 5'd0;
    drive(0, 64'd0, 5'd0, 0, 0, 0, 0);
    #2 check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // W-type sign extension and one-cycle latency
    drive(1, 64'h0000_0000_8000_0000, 5'd5, 1, 1, 0, 0);
    fwd_rs1 = 5'd5;
    tick("push_w");
    drive(0, 64'd0, 5'd0, 0, 0, 0, 0);
    #1;
    chk("w_sext.out_data", out_data, 64'hFFFF_FFFF_8000_0000);
    chk("w_sext.out_wen",  64'(out_wen), 64'd1);
    chk("w_sext.fwd_data1", fwd_data1, 64'hFFFF_FFFF_8000_0000);
    out_ready = 1'b1;
    tick("pop_w");

    // x0 is never written nor forwarded
    drive(1, 64'd7, 5'd0, 1, 0, 0, 0);
    fwd_rs1 = 5'd0;
    tick("push_x0");
    drive(0, 64'd0, 5'd0, 0, 0, 0, 0);
    #1;
    chk("x0.out_wen",  64'(out_wen),  64'd0);
    chk("x0.fwd_hit1", 64'(fwd_hit1), 64'd0);
    chk("x0.out_data", out_data, 64'd7);
    out_ready = 1'b1;
    tick("pop_x0");

    // Backpressure: third result held until space frees
    drive(1, 64'd1, 5'd1, 1, 0, 0, 0); tick("bp1");
    drive(1, 64'd2, 5'd2, 1, 0, 0, 0); tick("bp2");
    drive(1, 64'd3, 5'd3, 1, 0, 0, 0);
    #1 chk("bp.full_in_ready", 64'(in_ready), 64'd0);
    tick("bp3_held");
    out_ready = 1'b1;
    #1 chk("bp.first", out_data, 64'd1);
    tick("bp_pop1");
    #1 chk("bp.second", out_data, 64'd2);
    tick("bp_pop2_push3");
    in_valid = 1'b0;
    #1 chk("bp.third", out_data, 64'd3);
    tick("bp_pop3");
    out_ready = 1'b0;
    #1 chk("bp.empty", 64'(out_valid), 64'd0);

    // Youngest match wins; current-cycle push not yet visible
    fwd_rs1 = 5'd3;
    fwd_rs2 = 5'd3;
    drive(1, 64'd10, 5'd3, 1, 0, 0, 0); tick("young1");
    drive(1, 64'd20, 5'd3, 1, 0, 0, 0);
    #1 chk("young.same_cycle", fwd_data1, 64'd10);
    tick("young2");
    drive(0, 64'd0, 5'd0, 0, 0, 0, 0);
    #1;
    chk("young.hit1",  64'(fwd_hit1), 64'd1);
    chk("young.data1", fwd_data1, 64'd20);
    out_ready = 1'b1;
    tick("young_pop1");
    tick("young_pop2");

    // Flush dominates a coincident push and pop
    drive(1, 64'd42, 5'd4, 1, 0, 0, 0); tick("fl_push");
    drive(1, 64'd43, 5'd6, 1, 0, 1, 1);
    tick("flush");
    drive(0, 64'd0, 5'd0, 0, 0, 0, 0);
    #1;
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    tick("post_flush");

    // Asynchronous reset while full
    drive(1, 64'd5, 5'd7, 1, 0, 0, 0); tick("rf1");
    drive(1, 64'd6, 5'd8, 1, 0, 0, 0); tick("rf2");
    drive(0, 64'd0, 5'd0, 0, 0, 0, 0);
    fwd_rs1 = 5'd7;
    #1 chk("rf.full", 64'(in_ready), 64'd0);
    #1 reset_n = 1'b0;
    q.delete();
    #1;
    chk("rst_async.out_valid", 64'(out_valid), 64'd0);
    chk("rst_async.in_ready",  64'(in_ready),  64'd1);
    chk("rst_async.fwd_hit1",  64'(fwd_hit1),  64'd0);
    check_all("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 64'd99, 5'd9, 1, 0, 0, 0); tick("after_rst");
    drive(0, 64'd0, 5'd0, 0, 0, 0, 0);
    #1 chk("after_rst.out_data", out_data, 64'd99);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, {$urandom, $urandom}, 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      fwd_rs1 = 5'($urandom_range(0, 7));
      fwd_rs2 = 5'($urandom_range(0, 7));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
